uart_axil_ctrl: RTL

AXI4-Lite register front-end for the UART, successor to the single-address write-only controller. Exposes a word-aligned register map (DATA, STATUS, CTRL) at a parametrised base address. Moves bytes between the bus and the TX/RX buffer streams with full read and write paths and sticky error status. Sits between the system interconnect and the UART TX/RX buffers.

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_status_reg.sv | 50 +++++
 rtl/uart_axil_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART AXI4-Lite front-end.
// Holds the bus response encoding, the register offsets, the STATUS/CTRL
// bit positions and the state types of the write and read FSMs.
package uart_pkg;

    // AXI response codes used by this block
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Register offsets relative to BASE_ADDR
    localparam logic [3:0] DATA_OFS   = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] CTRL_OFS   = 4'h8;

    // STATUS bit positions
    localparam int ST_TX_READY = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_TX_OVF   = 2;
    localparam int ST_RX_OVF   = 3;
    localparam int ST_RX_UDF   = 4;

    // CTRL bit positions (interrupt enables)
    localparam int CTRL_RX_IE  = 0;
    localparam int CTRL_TX_IE  = 1;
    localparam int CTRL_ERR_IE = 2;
    localparam int CTRL_W      = 3;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PUSH,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_POP,
        R_RESP
    } rd_state_t;

    // Result of decoding a bus address against the register map
    typedef enum logic [1:0] {
        SEL_DATA,
        SEL_STATUS,
        SEL_CTRL,
        SEL_BAD
    } reg_sel_t;

endpackage

// File: rtl/uart_status_reg.sv
// uart_status_reg: sticky error flags and STATUS word assembly.
// Flags are set by single-cycle pulses and cleared by a STATUS read; a set
// arriving in the same cycle as the clear is kept.
module uart_status_reg
    import uart_pkg::*;
#(
    parameter int DLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            tx_ovf_set,
    input  logic            rx_ovf_set,
    input  logic            rx_udf_set,
    input  logic            clear,
    input  logic            tx_ready,
    input  logic            rx_valid,
    output logic [DLEN-1:0] status
);

    logic tx_ovf;
    logic rx_ovf;
    logic rx_udf;

    // Sticky flags: clear first, then OR in the set so a coincident set wins
    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // blocking assignments here would make results depend on statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
            rx_udf <= 1'b0;
        end else begin
            tx_ovf <= (tx_ovf & ~clear) | tx_ovf_set;
            rx_ovf <= (rx_ovf & ~clear) | rx_ovf_set;
            rx_udf <= (rx_udf & ~clear) | rx_udf_set;
        end
    end

    // STATUS word: live stream flags plus the sticky bits, all others zero
    // NOTE: the whole word gets a default first so no bit can infer a latch.
    always_comb begin
        status              = '0;
        status[ST_TX_READY] = tx_ready;
        status[ST_RX_VALID] = rx_valid;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_RX_OVF]   = rx_ovf;
        status[ST_RX_UDF]   = rx_udf;
    end

endmodule

// File: rtl/uart_axil_ctrl.sv
// uart_axil_ctrl: AXI4-Lite register front-end for the UART TX/RX buffers.
// Map at BASE_ADDR: 0x0 DATA (write pushes TX, read pops RX), 0x4 STATUS,
// 0x8 CTRL. Independent write and read FSMs; all AXI outputs are registered
// state, so no AXI input reaches an AXI output combinationally.
// Optional feature macro: UART_CTRL_IRQ_EN adds the CTRL register and o_irq.
module uart_axil_ctrl
    import uart_pkg::*;
#(
    parameter int                  AXI_ALEN  = 32,
    parameter int                  AXI_DLEN  = 32,
    parameter int                  AXI_SLEN  = AXI_DLEN / 8,
    parameter int                  UART_DLEN = 8,
    parameter logic [AXI_ALEN-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_axi_awvalid,
    output logic                 o_axi_awready,
    input  logic [AXI_ALEN-1:0]  i_axi_awaddr,
    input  logic                 i_axi_wvalid,
    output logic                 o_axi_wready,
    input  logic [AXI_DLEN-1:0]  i_axi_wdata,
    input  logic [AXI_SLEN-1:0]  i_axi_wstrb,
    output logic                 o_axi_bvalid,
    input  logic                 i_axi_bready,
    output logic [1:0]           o_axi_bresp,
    input  logic                 i_axi_arvalid,
    output logic                 o_axi_arready,
    input  logic [AXI_ALEN-1:0]  i_axi_araddr,
    output logic                 o_axi_rvalid,
    input  logic                 i_axi_rready,
    output logic [AXI_DLEN-1:0]  o_axi_rdata,
    output logic [1:0]           o_axi_rresp,
    output logic                 o_txb_tvalid,
    input  logic                 i_txb_tready,
    output logic [UART_DLEN-1:0] o_txb_tdata,
    input  logic                 i_txb_overflow,
    input  logic                 i_rxb_tvalid,
    output logic                 o_rxb_tready,
    input  logic [UART_DLEN-1:0] i_rxb_tdata,
    input  logic                 i_rxb_overflow,
    input  logic                 i_rxb_underflow
`ifdef UART_CTRL_IRQ_EN
    ,
    output logic                 o_irq
`endif
);

    // Map a bus address onto a register; anything off the exact offsets is bad
    function automatic reg_sel_t decode(input logic [AXI_ALEN-1:0] addr);
        logic [AXI_ALEN-1:0] ofs;
        ofs = addr - BASE_ADDR;
        if (ofs[AXI_ALEN-1:4] != '0) return SEL_BAD;
        case (ofs[3:0])
            DATA_OFS:   return SEL_DATA;
            STATUS_OFS: return SEL_STATUS;
`ifdef UART_CTRL_IRQ_EN
            CTRL_OFS:   return SEL_CTRL;
`endif
            default:    return SEL_BAD;
        endcase
    endfunction

    // Wide bus inputs of which only the low bits are used by the registers
    logic unused_bits;
    assign unused_bits = ^{i_axi_wdata, i_axi_wstrb};

    // Keeps every ready low while in reset and for the first cycle after it
    logic bus_en;

    // Held-flag register: goes high once after reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) bus_en <= 1'b0;
        else       bus_en <= 1'b1;
    end

    // ---------------------------------------------------------------- write
    wr_state_t            w_state;
    wr_state_t            w_next;
    logic                 aw_held;
    logic                 w_held;
    logic [AXI_ALEN-1:0]  aw_addr;
    logic [UART_DLEN-1:0] w_data;
    logic                 w_strb0;
    resp_t                b_resp;
    resp_t                w_resp_dec;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 w_go;
    logic [AXI_ALEN-1:0]  cur_addr;
    logic [UART_DLEN-1:0] cur_data;
    logic                 cur_strb0;
    reg_sel_t             w_sel;

    assign aw_hs     = i_axi_awvalid & o_axi_awready;
    assign w_hs      = i_axi_wvalid & o_axi_wready;
    assign cur_addr  = aw_held ? aw_addr : i_axi_awaddr;
    assign cur_data  = w_held ? w_data : i_axi_wdata[UART_DLEN-1:0];
    assign cur_strb0 = w_held ? w_strb0 : i_axi_wstrb[0];
    assign w_go      = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
    assign w_sel     = decode(cur_addr);

    // Write response implied by the decoded target
    always_comb begin
        w_resp_dec = DECERR;
        case (w_sel)
            SEL_DATA:   w_resp_dec = cur_strb0 ? OKAY : SLVERR;
            SEL_STATUS: w_resp_dec = SLVERR;
            SEL_CTRL:   w_resp_dec = cur_strb0 ? OKAY : SLVERR;
            default:    w_resp_dec = DECERR;
        endcase
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write FSM next state: decode as soon as both AW and W are in hand
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (w_go) w_next = (w_sel == SEL_DATA && cur_strb0) ? W_PUSH : W_RESP;
            W_PUSH:  if (i_txb_tready) w_next = W_RESP;
            W_RESP:  if (i_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Capture AW/W independently; drop the held flags once decoded
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb0 <= 1'b0;
            b_resp  <= OKAY;
        end else begin
            if (aw_hs) aw_addr <= i_axi_awaddr;
            if (w_hs) begin
                w_data  <= i_axi_wdata[UART_DLEN-1:0];
                w_strb0 <= i_axi_wstrb[0];
            end
            if (w_go) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                b_resp  <= w_resp_dec;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
        end
    end

    // Write FSM outputs
    always_comb begin
        o_axi_awready = bus_en & (w_state == W_IDLE) & ~aw_held;
        o_axi_wready  = bus_en & (w_state == W_IDLE) & ~w_held;
        o_axi_bvalid  = (w_state == W_RESP);
        o_axi_bresp   = b_resp;
        o_txb_tvalid  = (w_state == W_PUSH);
        o_txb_tdata   = w_data;
    end

    // ----------------------------------------------------------------- read
    rd_state_t           r_state;
    rd_state_t           r_next;
    logic [AXI_DLEN-1:0] r_data;
    resp_t               r_resp;
    logic                ar_hs;
    reg_sel_t            r_sel;
    logic [AXI_DLEN-1:0] rx_word;
    logic [AXI_DLEN-1:0] status_word;
    logic                pop_udf;
    logic                status_clr;

    assign ar_hs      = i_axi_arvalid & o_axi_arready;
    assign r_sel      = decode(i_axi_araddr);
    assign pop_udf    = (r_state == R_POP) & ~i_rxb_tvalid;
    assign status_clr = ar_hs & (r_sel == SEL_STATUS);

    // Zero-extend the RX character to the bus width
    always_comb begin
        rx_word                = '0;
        rx_word[UART_DLEN-1:0] = i_rxb_tdata;
    end

`ifdef UART_CTRL_IRQ_EN
    logic [CTRL_W-1:0]   ctrl;
    logic [AXI_DLEN-1:0] ctrl_word;

    always_comb begin
        ctrl_word             = '0;
        ctrl_word[CTRL_W-1:0] = ctrl;
    end

    // CTRL register: written by a decoded CTRL write with wstrb[0]
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                   ctrl <= '0;
        else if (w_go && w_sel == SEL_CTRL && cur_strb0) ctrl <= cur_data[CTRL_W-1:0];
    end

    // Registered interrupt level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) o_irq <= 1'b0;
        else       o_irq <= (ctrl[CTRL_RX_IE]  & i_rxb_tvalid)
                          | (ctrl[CTRL_TX_IE]  & i_txb_tready)
                          | (ctrl[CTRL_ERR_IE] & (|status_word[ST_RX_UDF:ST_TX_OVF]));
    end
`endif

    uart_status_reg #(
        .DLEN (AXI_DLEN)
    ) u_status (
        .clk        (clk),
        .rstn       (rstn),
        .tx_ovf_set (i_txb_overflow),
        .rx_ovf_set (i_rxb_overflow),
        .rx_udf_set (i_rxb_underflow | pop_udf),
        .clear      (status_clr),
        .tx_ready   (i_txb_tready),
        .rx_valid   (i_rxb_tvalid),
        .status     (status_word)
    );

    // Read FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state: DATA reads detour through the one-cycle pop
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = (r_sel == SEL_DATA) ? R_POP : R_RESP;
            R_POP:   r_next = R_RESP;
            R_RESP:  if (i_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read data/response capture; STATUS is sampled before its sticky clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= '0;
            r_resp <= OKAY;
        end else if (ar_hs) begin
            case (r_sel)
                SEL_STATUS: begin
                    r_data <= status_word;
                    r_resp <= OKAY;
                end
`ifdef UART_CTRL_IRQ_EN
                SEL_CTRL: begin
                    r_data <= ctrl_word;
                    r_resp <= OKAY;
                end
`endif
                SEL_DATA: begin
                    r_data <= '0;
                    r_resp <= OKAY;
                end
                default: begin
                    r_data <= '0;
                    r_resp <= DECERR;
                end
            endcase
        end else if (r_state == R_POP) begin
            if (i_rxb_tvalid) begin
                r_data <= rx_word;
                r_resp <= OKAY;
            end else begin
                r_data <= '0;
                r_resp <= SLVERR;
            end
        end
    end

    // Read FSM outputs
    always_comb begin
        o_axi_arready = bus_en & (r_state == R_IDLE);
        o_axi_rvalid  = (r_state == R_RESP);
        o_axi_rdata   = r_data;
        o_axi_rresp   = r_resp;
        o_rxb_tready  = (r_state == R_POP);
    end

endmodule
